// File: rtl/router_mon_pkg.sv
// Shared types and constants for the HeMPS router link monitor.
package router_mon_pkg;

    // Flit width used across the HeMPS tile (hemps_defaults).
    localparam int HEMPS_FLIT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2
    } mon_state_e;

    localparam int ERR_HOLD    = 0;
    localparam int ERR_SIZE    = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_W       = 3;

    typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/router_link_monitor_ch.sv
// One monitored link: packet framing FSM, idle counter and sticky error flags.
// Optional statistics counters under ROUTER_MON_STATS_EN.
module router_link_monitor_ch
    import router_mon_pkg::*;
#(
    parameter int FLIT_WIDTH   = HEMPS_FLIT_WIDTH,
    parameter int MAX_PKT_SIZE = 128,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic                  credit,
    input  logic                  err_clr,
    output logic [ERR_W-1:0]      err,
    output logic                  busy
`ifdef ROUTER_MON_STATS_EN
    ,
    output logic [31:0]           flit_cnt,
    output logic [31:0]           pkt_cnt
`endif
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [FLIT_WIDTH-1:0] MAX_SZ  = FLIT_WIDTH'(MAX_PKT_SIZE);
    localparam logic [FLIT_WIDTH-1:0] ONE     = FLIT_WIDTH'(1);

    mon_state_e            state_q, state_d;
    logic [FLIT_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]      idle_q, idle_d;
    logic [FLIT_WIDTH-1:0] prev_q, prev_d;
    logic                  stall_q, stall_d;
    err_vec_t              err_q, err_d;
    err_vec_t              set;
    logic                  xfer;

    assign xfer = rx & credit;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idle_d  = idle_q;
        set     = '0;
        stall_d = rx & ~credit;
        prev_d  = data_in;

        // A stalled flit must be held: neither retracted nor altered.
        if (stall_q && (!rx || data_in != prev_q))
            set[ERR_HOLD] = 1'b1;

        if (xfer) begin
            idle_d = '0;
            case (state_q)
                IDLE: state_d = SIZE;
                SIZE: begin
                    rem_d = data_in;
                    if (data_in > MAX_SZ)
                        set[ERR_SIZE] = 1'b1;
                    state_d = (data_in == '0) ? IDLE : PAYLOAD;
                end
                PAYLOAD: begin
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            idle_d = '0;
        end else if (TIMEOUT != 0 && idle_q == TO_LAST) begin
            // This edge brings the idle count to TIMEOUT: abandon the packet.
            set[ERR_TIMEOUT] = 1'b1;
            state_d          = IDLE;
            idle_d           = '0;
        end else if (idle_q != CNT_MAX) begin
            idle_d = idle_q + 1'b1;
        end

        err_d = (err_q & ~{ERR_W{err_clr}}) | set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idle_q  <= '0;
            prev_q  <= '0;
            stall_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idle_q  <= idle_d;
            prev_q  <= prev_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err  = err_q;
    assign busy = (state_q != IDLE);

`ifdef ROUTER_MON_STATS_EN
    logic [31:0] flit_q, flit_d;
    logic [31:0] pkt_q, pkt_d;
    logic        pkt_done;

    // Normal end of packet only; timeout returns are not counted.
    assign pkt_done = xfer && ((state_q == SIZE && data_in == '0) ||
                               (state_q == PAYLOAD && rem_q == ONE));

    always_comb begin
        flit_d = flit_q + {31'd0, xfer};
        pkt_d  = pkt_q + {31'd0, pkt_done};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flit_q <= '0;
            pkt_q  <= '0;
        end else begin
            flit_q <= flit_d;
            pkt_q  <= pkt_d;
        end
    end

    assign flit_cnt = flit_q;
    assign pkt_cnt  = pkt_q;
`endif

endmodule

// File: rtl/router_link_monitor.sv
// Passive monitor for NPORT credit-based router links with a registered irq.
// Define ROUTER_MON_STATS_EN to add per-channel flit/packet counters.
module router_link_monitor
    import router_mon_pkg::*;
#(
    parameter int NPORT        = 5,
    parameter int FLIT_WIDTH   = HEMPS_FLIT_WIDTH,
    parameter int MAX_PKT_SIZE = 128,
    parameter int TIMEOUT      = 1024
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NPORT-1:0]                    rx,
    input  logic [NPORT-1:0][FLIT_WIDTH-1:0]    data_in,
    input  logic [NPORT-1:0]                    credit,
    input  logic [NPORT-1:0]                    err_clr,
    output logic [NPORT-1:0][ERR_W-1:0]         err,
    output logic [NPORT-1:0]                    busy,
    output logic                                irq
`ifdef ROUTER_MON_STATS_EN
    ,
    output logic [NPORT-1:0][31:0]              flit_cnt,
    output logic [NPORT-1:0][31:0]              pkt_cnt
`endif
);

    logic irq_q, irq_d;

    for (genvar g = 0; g < NPORT; g++) begin : g_ch
        router_link_monitor_ch #(
            .FLIT_WIDTH   (FLIT_WIDTH),
            .MAX_PKT_SIZE (MAX_PKT_SIZE),
            .TIMEOUT      (TIMEOUT)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .rx       (rx[g]),
            .data_in  (data_in[g]),
            .credit   (credit[g]),
            .err_clr  (err_clr[g]),
            .err      (err[g]),
            .busy     (busy[g])
`ifdef ROUTER_MON_STATS_EN
            ,
            .flit_cnt (flit_cnt[g]),
            .pkt_cnt  (pkt_cnt[g])
`endif
        );
    end

    always_comb irq_d = |err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;

endmodule

// File: doc/router_link_monitor.md
# router_link_monitor

Synthesizable, parametrised run-time monitor for the credit-based links of the HeMPS router. It observes NPORT links at once and decodes each link's packets: header flit, then size flit, then payload flits. It reports sticky protocol errors per channel: stall instability, oversize packet and stalled-packet timeout. It sits beside the router in the tile, is purely passive (never drives the links), and raises a single interrupt line to the local processor.

## Interface
Parameters:
- NPORT, 5, number of monitored links (channels)
- FLIT_WIDTH, 16, flit width in bits
- MAX_PKT_SIZE, 128, largest legal size-flit value (payload flits)
- TIMEOUT, 1024, idle cycles tolerated inside an open packet; 0 disables the timeout check

Ports:
- clock  in  1  single clock for the whole block, rising edge
- reset  in  1  asynchronous, active-low reset
- rx  in  NPORT  per-link flit-valid
- data_in  in  NPORT×FLIT_WIDTH  per-link flit
- credit  in  NPORT  per-link receiver credit
- err_clr  in  NPORT  per-channel pulse; clears that channel's sticky errors
- err  out  NPORT×3  sticky flags per channel: [0] HOLD, [1] SIZE, [2] TIMEOUT
- busy  out  NPORT  channel is inside a packet (state ≠ IDLE)
- irq  out  1  OR of all err bits, registered

## Operation
- Transfer on channel i happens when rx[i] && credit[i] at a rising edge.
- Per-channel FSM, advanced only on a transfer:
  - IDLE: header transfer → SIZE.
  - SIZE: latch data_in as remaining = size. Size 0 → IDLE. Otherwise → PAYLOAD.
  - PAYLOAD: remaining decrements on each transfer. The transfer that takes remaining from 1 to 0 → IDLE.
- HOLD error: set if the previous cycle had rx && !credit (a stall) and this cycle has either of:
  - rx low (the flit was retracted);
  - data_in different from the registered previous data.
- SIZE error: set when the size flit is greater than MAX_PKT_SIZE. The FSM still follows the size it latched, so framing keeps tracking the traffic.
- TIMEOUT error:
  - An idle counter clears on every transfer and while the channel is in IDLE, and increments otherwise.
  - When the counter reaches TIMEOUT: set the error, force the FSM to IDLE, clear the counter.
  - The counter saturates; it never wraps.
- Error flags are sticky until err_clr[i]. If err_clr and a new error set occur in the same cycle, set wins.
- Channels are fully independent. No cross-channel state except irq.

## Timing
- Reset values:
  - err = 0, busy = 0, irq = 0;
  - FSMs in IDLE;
  - remaining = 0, idle counter = 0, previous-data/stall registers = 0.
- The FSM state, and therefore busy, updates on the edge that samples the transfer. busy rises one cycle after the header transfer.
- err bits assert on the edge that samples the offending condition. They are visible the cycle after the offending inputs.
- irq has one additional cycle of latency over err, for a registered OR.
- A reset assertion mid-packet drops all state immediately, asynchronously. After release, the first transfer is treated as a header.
- remaining is FLIT_WIDTH bits. The size flit is taken unsigned in full width.
- Back-to-back packets are legal: a header is accepted in the cycle right after the last payload transfer.

## Configuration
- ROUTER_MON_STATS_EN defined:
  - Adds per-channel outputs flit_cnt (NPORT×32) and pkt_cnt (NPORT×32).
  - Both counters wrap modulo 2^32.
  - flit_cnt increments on every transfer.
  - pkt_cnt increments when the FSM returns to IDLE normally; timeout returns do not count.
  - Both clear on reset only.
- ROUTER_MON_STATS_EN undefined: the counters and their ports are absent. Error behaviour is identical.

## Structure
- Shared package router_mon_pkg holds:
  - the FSM enum: IDLE, SIZE, PAYLOAD;
  - error bit index constants ERR_HOLD = 0, ERR_SIZE = 1, ERR_TIMEOUT = 2;
  - the err vector typedef.
- FLIT_WIDTH defaults are taken from hemps_defaults.
- Sub-module router_link_monitor_ch implements one channel: FSM, counters, error flags. The top module generates NPORT instances and the irq OR.

## Test plan
- Packet 0x0011, size 3, payload A, B, C on channel 0 with credit held high → busy high for 4 cycles, returns to IDLE, err = 0. With stats compiled in: flit_cnt = 5, pkt_cnt = 1.
- Channel 2 stalls: rx = 1, credit = 0, data 0x1234, then data changes to 0x1235 while still stalled → err[2][ERR_HOLD] set next cycle, irq one cycle later. err_clr[2] then clears it.
- Size flit 0x0081 (129) with MAX_PKT_SIZE = 128 → ERR_SIZE set, and the FSM still consumes 129 payload flits before IDLE.
- Header and size 2, one payload, then no transfers for TIMEOUT = 16 cycles → ERR_TIMEOUT set at the 16th idle cycle, busy drops. The next flit is accepted as a header.
- Size 0 packet followed immediately by a new header on the next cycle → both packets framed correctly, no errors.
- reset asserted mid-payload on channel 4, with err_clr and a HOLD violation coinciding on channel 1 → channel 4 returns to IDLE at once with all outputs 0 after release. Channel 1 ends with ERR_HOLD set (set wins).
